// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers propagate/generate and group terms; stage 2 resolves carries and flags.
module cla_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
      $error("cla_adder_pipe: WIDTH must be a multiple of 4 in the range 4..64");
    end
  endgenerate

  logic s1_valid;
  logic s2_valid;
  logic adv1;
  logic adv2;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // ---------------- stage 1: operand conditioning and group terms ----------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH-1:0] g_nx;
  logic             c0_nx;
  logic [NG-1:0]    gp_nx;
  logic [NG-1:0]    gg_nx;
  logic [3*NG-1:0]  g_lo_nx;

  assign b_eff = b ^ {WIDTH{sub}};
  assign c0_nx = sub ? ~cin : cin;
  assign p_nx  = a ^ b_eff;
  assign g_nx  = a & b_eff;

  for (genvar gi = 0; gi < NG; gi++) begin : g_s1_grp
    logic [3:0] pl;
    logic [3:0] gl;
    assign pl = p_nx[4*gi +: 4];
    assign gl = g_nx[4*gi +: 4];
    assign gp_nx[gi] = &pl;
    assign gg_nx[gi] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                     | (pl[3] & pl[2] & pl[1] & gl[0]);
    // The top generate bit of each group only matters through GG, so it is not kept.
    assign g_lo_nx[3*gi +: 3] = gl[2:0];
  end

  logic [WIDTH-1:0] s1_p;
  logic [3*NG-1:0]  s1_g_lo;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;
  logic             s1_c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g_lo  <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_c0    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p    <= p_nx;
        s1_g_lo <= g_lo_nx;
        s1_gp   <= gp_nx;
        s1_gg   <= gg_nx;
        s1_c0   <= c0_nx;
      end
    end
  end

  // ---------------- stage 2: group lookahead, bit carries, flags ----------------
  // Each group carry is a flat sum of products over GG/GP and c0, no inter-group ripple.
  logic [NG:0] cg;
  logic        gp_run;

  always_comb begin
    cg     = '0;
    gp_run = 1'b1;
    cg[0]  = s1_c0;
    for (int k = 1; k <= NG; k++) begin
      gp_run = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        cg[k]  = cg[k] | (s1_gg[j] & gp_run);
        gp_run = gp_run & s1_gp[j];
      end
      cg[k] = cg[k] | (s1_c0 & gp_run);
    end
  end

  logic [WIDTH-1:0] c_bit;

  for (genvar gi = 0; gi < NG; gi++) begin : g_s2_grp
    logic [3:0] pl;
    logic [2:0] gl;
    logic       ci;
    assign pl = s1_p[4*gi +: 4];
    assign gl = s1_g_lo[3*gi +: 3];
    assign ci = cg[gi];
    assign c_bit[4*gi]   = ci;
    assign c_bit[4*gi+1] = gl[0] | (pl[0] & ci);
    assign c_bit[4*gi+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
    assign c_bit[4*gi+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                         | (pl[2] & pl[1] & pl[0] & ci);
  end

  logic [WIDTH-1:0] sum_nx;
  logic             cout_nx;
  logic             ovf_nx;
  logic             zero_nx;

  assign sum_nx  = s1_p ^ c_bit;
  assign cout_nx = cg[NG];
  assign ovf_nx  = c_bit[WIDTH-1] ^ cg[NG];
  assign zero_nx = (sum_nx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_nx;
        cout <= cout_nx;
        ovf  <= ovf_nx;
        zero <= zero_nx;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe at WIDTH=16: directed vectors, backpressure,
// mid-stream reset, a randomised handshake run and a full-throughput run.
module tb_cla_adder_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } res_t;

  res_t sb[$];
  vec_t vq[$];
  res_t e_res;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc = 0;
  int   n_pop = 0;

  function automatic vec_t mk(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                              input logic cin_i, input logic sub_i,
                              input logic [W-1:0] s_i, input logic co_i,
                              input logic ov_i, input logic z_i);
    vec_t v;
    v.a = a_i; v.b = b_i; v.cin = cin_i; v.sub = sub_i;
    v.s = s_i; v.co = co_i; v.ov = ov_i; v.z = z_i;
    return v;
  endfunction

  // Behavioural reference: plain wide addition, carry into MSB from the low W-1 bits.
  function automatic vec_t model_vec(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                     input logic cin_i, input logic sub_i);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   full;
    logic [W-1:0] low;
    vec_t         v;
    bb   = sub_i ? ~b_i : b_i;
    c0   = sub_i ? ~cin_i : cin_i;
    full = {1'b0, a_i} + {1'b0, bb} + {{W{1'b0}}, c0};
    low  = {1'b0, a_i[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, c0};
    v.a = a_i; v.b = b_i; v.cin = cin_i; v.sub = sub_i;
    v.s  = full[W-1:0];
    v.co = full[W];
    v.ov = low[W-1] ^ full[W];
    v.z  = (full[W-1:0] == '0);
    return v;
  endfunction

  // Monitor: outputs are stable from just after the posedge; a beat is consumed on the
  // next posedge when out_valid && out_ready.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_out sum=%h cout=%b ovf=%b zero=%b with empty scoreboard",
                 sum, cout, ovf, zero);
      end else begin
        e_res = sb.pop_front();
        n_pop++;
        if ({sum, cout, ovf, zero} !== e_res) begin
          n_errors++;
          $display("FAIL result[%0d] got sum=%h cout=%b ovf=%b zero=%b exp sum=%h cout=%b ovf=%b zero=%b",
                   n_pop, sum, cout, ovf, zero, e_res.s, e_res.co, e_res.ov, e_res.z);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // mode 0: out_ready low; 1: out_ready and in_valid high; 2: both randomised
  task automatic stream(input int max_cyc, input int mode);
    vec_t v;
    n_acc = 0;
    for (int c = 0; c < max_cyc && vq.size() > 0; c++) begin
      @(negedge clk);
      out_ready = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        v = vq[0];
        in_valid = 1'b1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      end
      #1;
      if (in_valid && in_ready) begin
        v = vq.pop_front();
        sb.push_back({v.s, v.co, v.ov, v.z});
        n_acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    int pop0;
    logic [31:0] r1;
    logic [31:0] r2;

    // reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_flags", {sum, cout, ovf, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 1);

    // directed arithmetic vectors
    vq.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0));
    vq.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1));
    vq.push_back(mk(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0));
    stream(40, 1);
    drain();

    // backpressure: only two beats fit while the output is stalled
    vq.push_back(mk(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0));
    stream(6, 0);
    check("bp_accepted", n_acc, 2);
    #1;
    check("bp_in_ready", {31'd0, in_ready}, 0);
    check("bp_out", {15'd0, out_valid, sum}, {15'd0, 1'b1, 16'h0002});
    repeat (3) @(negedge clk);
    #1;
    check("bp_hold", {sum, cout, ovf, zero}, {16'h0002, 3'b000});
    pop0 = n_pop;
    stream(20, 1);
    drain();
    check("bp_pops", n_pop - pop0, 4);

    // reset with two beats in flight
    vq.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0));
    stream(3, 0);
    check("mid_in_flight", {31'd0, out_valid}, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_flags", {sum, cout, ovf, zero}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("no_stale", {31'd0, out_valid}, 0);

    // randomised handshake regression
    for (int i = 0; i < 300; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      vq.push_back(model_vec(r1[W-1:0], r2[W-1:0], r1[31], r2[31]));
    end
    stream(3000, 2);
    check("rand_accepted", n_acc, 300);
    drain();

    // full throughput: one beat per cycle in, one per cycle out
    for (int i = 0; i < 50; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      vq.push_back(model_vec(r1[W-1:0], r2[W-1:0], r1[30], r2[30]));
    end
    pop0 = n_pop;
    stream(50, 1);
    check("thru_accepted", n_acc, 50);
    drain();
    check("thru_pops", n_pop - pop0, 50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
